fma_norm_round: RTL and testbench

- Final stage of the single-precision fused multiply-add datapath.
- Consumes the 48-bit unnormalised magnitude from the add stage and the position produced by the upstream leading-one detector.
- Normalises, applies round-to-nearest-even and packs an IEEE-754 binary32 result with exception flags.
- Two-stage valid/ready pipeline, so the combinational detector output is registered before the wide shift.

---
 rtl/fma_pkg.sv | 18 +
 rtl/fma_round_pack.sv | 50 +++++
 rtl/fma_norm_round.sv | 115 +++++++++++
 tb/tb_fma_norm_round.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared constants and types for the binary32 FMA normalise/round/pack stage.
// The magnitude is aligned so that bit NORM_POS carries weight 2^0 at the incoming exponent.
package fma_pkg;
    localparam int MW       = 48;
    localparam int EW       = 10;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam int NORM_POS = 46;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fma_flags_t;
endpackage

// File: rtl/fma_round_pack.sv
// Combinational round-to-nearest-even and binary32 packing of a normalised magnitude.
// frac_in holds the bits below the (implicit) leading one; exponent range checks happen after rounding.
module fma_round_pack
    import fma_pkg::*;
(
    input  logic                 sign,
    input  logic                 zero,
    input  logic [NORM_POS-1:0]  frac_in,
    input  logic                 shout,
    input  logic signed [EW:0]   exp_adj,
    output logic [31:0]          result,
    output fma_flags_t           flags
);
    localparam logic signed [EW:0] EXP_TOP  = (EW+1)'(EXP_MAX);
    localparam logic signed [EW:0] EXP_NONE = '0;

    logic [FRAC_W-1:0]    frac;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [FRAC_W:0]      frac_sum;
    logic signed [EW:0]   exp_r;

    always_comb begin
        frac     = frac_in[NORM_POS-1 -: FRAC_W];
        guard    = frac_in[NORM_POS-1-FRAC_W];
        sticky   = (|frac_in[NORM_POS-2-FRAC_W:0]) | shout;
        round_up = guard & (sticky | frac[0]);
        // A carry out of the fraction means the significand reached 2^24; the low bits are then zero.
        frac_sum = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
        exp_r    = exp_adj + $signed({{EW{1'b0}}, frac_sum[FRAC_W]});

        result = '0;
        flags  = '0;
        if (zero) begin
            result = {sign, {(EXP_W+FRAC_W){1'b0}}};
        end else if (exp_r >= EXP_TOP) begin
            result    = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags.ovf = 1'b1;
            flags.inx = 1'b1;
        end else if (exp_r <= EXP_NONE) begin
            result    = {sign, {(EXP_W+FRAC_W){1'b0}}};
            flags.unf = 1'b1;
            flags.inx = 1'b1;
        end else begin
            result    = {sign, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
            flags.inx = guard | sticky;
        end
    end
endmodule

// File: rtl/fma_norm_round.sv
// Final FMA stage: registers the raw sum and detector position, normalises, rounds and packs.
// Handshake: a beat moves on valid&ready; each stage loads when empty or when its successor moves.
module fma_norm_round
    import fma_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MW-1:0]   mant_in,
    input  logic [7:0]      lead_pos,
    input  logic [EW-1:0]   exp_in,
    input  logic            sign_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     result,
    output logic            flag_ovf,
    output logic            flag_unf,
    output logic            flag_inx
);
    localparam logic signed [EW:0] EXP_ONE = (EW+1)'(1);

    logic            s1_valid;
    logic [MW-1:0]   s1_mant;
    logic [7:0]      s1_lead;
    logic [EW-1:0]   s1_exp;
    logic            s1_sign;

    logic            s2_valid;
    logic [31:0]     s2_result;
    fma_flags_t      s2_flags;

    logic            s1_adv;
    logic            s2_adv;

    logic                 zero;
    logic [7:0]           shamt;
    logic [NORM_POS-1:0]  norm;
    logic                 shout;
    logic signed [EW:0]   exp_adj;
    logic [31:0]          rp_result;
    fma_flags_t           rp_flags;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_lead  <= '0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant <= mant_in;
                s1_lead <= lead_pos;
                s1_exp  <= exp_in;
                s1_sign <= sign_in;
            end
        end
    end

    // The detector output is meaningless for a zero magnitude, and out-of-range positions are treated alike.
    always_comb begin
        zero    = (s1_mant == '0) || (s1_lead > 8'(NORM_POS + 1));
        shamt   = '0;
        norm    = NORM_POS'(s1_mant);
        shout   = 1'b0;
        exp_adj = {s1_exp[EW-1], s1_exp};
        if (!zero) begin
            if (s1_lead == 8'(NORM_POS + 1)) begin
                norm    = NORM_POS'(s1_mant >> 1);
                shout   = s1_mant[0];
                exp_adj = {s1_exp[EW-1], s1_exp} + EXP_ONE;
            end else begin
                shamt   = 8'(NORM_POS) - s1_lead;
                norm    = NORM_POS'(s1_mant << shamt);
                exp_adj = {s1_exp[EW-1], s1_exp} - $signed({{(EW+1-8){1'b0}}, shamt});
            end
        end
    end

    fma_round_pack u_round_pack (
        .sign    (s1_sign),
        .zero    (zero),
        .frac_in (norm),
        .shout   (shout),
        .exp_adj (exp_adj),
        .result  (rp_result),
        .flags   (rp_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= rp_result;
                s2_flags  <= rp_flags;
            end
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flag_ovf  = s2_flags.ovf;
    assign flag_unf  = s2_flags.unf;
    assign flag_inx  = s2_flags.inx;
endmodule

// File: tb/tb_fma_norm_round.sv
// Bench for fma_norm_round: directed vectors plus random traffic against an arithmetic model.
// Expected results are {ovf, unf, inx, result}.
module tb_fma_norm_round;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] mant_in;
    logic [7:0]  lead_pos;
    logic [9:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;

    int checks = 0;
    int errors = 0;
    logic [34:0] exp_q[$];

    fma_norm_round dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .lead_pos  (lead_pos),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_ovf  (flag_ovf),
        .flag_unf  (flag_unf),
        .flag_inx  (flag_inx)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // Value = mant * 2^(exp - 127 - 46); round the significand to 24 bits, nearest-even.
    function automatic logic [34:0] ref_model(input logic [47:0] m, input int e, input logic s);
        longint unsigned mm, q, rem, half;
        int p, k, er;
        logic inx;
        if (m == 48'h0) return {3'b000, s, 31'h0};
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        mm  = 64'(m);
        k   = p - 23;
        er  = e + p - 46;
        inx = 1'b0;
        if (k > 0) begin
            q    = mm >> k;
            rem  = mm & ((64'd1 << k) - 64'd1);
            half = 64'd1 << (k - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end else begin
            q = mm << (-k);
        end
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            er = er + 1;
        end
        if (er >= 255) return {3'b101, s, 8'hFF, 23'h0};
        if (er <= 0)   return {3'b011, s, 31'h0};
        return {2'b00, inx, s, 8'(er), q[22:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        in_valid = 1'b0;
        mant_in  = '0;
        lead_pos = '0;
        exp_in   = '0;
        sign_in  = 1'b0;
    endtask

    task automatic gen_beat(output logic [47:0] m, output logic [7:0] l, output int e, output logic s);
        int w;
        logic [63:0] r;
        w = $urandom_range(0, 48);
        r = {$urandom(), $urandom()};
        m = r[47:0];
        if (w == 0) begin
            m = '0;
            l = 8'($urandom_range(0, 255));
        end else begin
            m = m & ((48'h1 << w) - 48'h1);
            m[w-1] = 1'b1;
            l = 8'(w - 1);
        end
        e = int'($urandom_range(0, 420)) - 110;
        s = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_beat(input logic [47:0] m, input logic [7:0] l, input int e, input logic s);
        in_valid = 1'b1;
        mant_in  = m;
        lead_pos = l;
        exp_in   = 10'(e);
        sign_in  = s;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_hold: got valid/ready=%b, expected 01", {out_valid, in_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, result, flag_ovf, flag_unf, flag_inx, in_ready} !== {1'b0, 32'h0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b result=%h flags=%b ready=%b, expected 0 00000000 000 1",
                     out_valid, result, {flag_ovf, flag_unf, flag_inx}, in_ready);
        end
    endtask

    typedef struct {
        string       name;
        logic [47:0] m;
        logic [7:0]  l;
        int          e;
        logic        s;
        logic [34:0] x;
    } vec_t;

    task automatic test_directed();
        vec_t v[14];
        v[0]  = '{"one",        48'h4000_0000_0000, 8'd46, 127, 1'b0, {3'b000, 32'h3F80_0000}};
        v[1]  = '{"two_rshift", 48'h8000_0000_0000, 8'd47, 127, 1'b0, {3'b000, 32'h4000_0000}};
        v[2]  = '{"tie_even",   48'h4000_0040_0000, 8'd46, 127, 1'b0, {3'b001, 32'h3F80_0000}};
        v[3]  = '{"tie_odd",    48'h4000_00C0_0000, 8'd46, 127, 1'b0, {3'b001, 32'h3F80_0002}};
        v[4]  = '{"carry_ovf",  48'h7FFF_FFFF_FFFF, 8'd46, 254, 1'b0, {3'b101, 32'h7F80_0000}};
        v[5]  = '{"carry_norm", 48'h7FFF_FFFF_FFFF, 8'd46, 127, 1'b0, {3'b001, 32'h4000_0000}};
        v[6]  = '{"underflow",  48'h0100_0000_0000, 8'd40, 5,   1'b0, {3'b011, 32'h0000_0000}};
        v[7]  = '{"zero",       48'h0,              8'h2F, 127, 1'b1, {3'b000, 32'h8000_0000}};
        v[8]  = '{"bad_lead",   48'h4000_0000_0000, 8'd200, 127, 1'b0, {3'b000, 32'h0000_0000}};
        v[9]  = '{"negative",   48'h4000_0000_0000, 8'd46, 130, 1'b1, {3'b000, 32'hC100_0000}};
        v[10] = '{"max_exp",    48'h4000_0000_0000, 8'd46, 254, 1'b0, {3'b000, 32'h7F00_0000}};
        v[11] = '{"exp_255",    48'h4000_0000_0000, 8'd46, 255, 1'b1, {3'b101, 32'hFF80_0000}};
        v[12] = '{"min_exp",    48'h4000_0000_0000, 8'd46, 1,   1'b0, {3'b000, 32'h0080_0000}};
        v[13] = '{"exp_0",      48'h4000_0000_0000, 8'd46, 0,   1'b0, {3'b011, 32'h0000_0000}};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_beat(v[i].m, v[i].l, v[i].e, v[i].s);
            @(negedge clk);
            set_idle();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_latency: got out_valid=%b one cycle after accept, expected 0", v[i].name, out_valid);
            end
            @(negedge clk);
            checks++;
            if ({out_valid, flag_ovf, flag_unf, flag_inx, result} !== {1'b1, v[i].x}) begin
                errors++;
                $display("FAIL %s: got valid=%b flags=%b result=%h, expected 1 %b %h", v[i].name,
                         out_valid, {flag_ovf, flag_unf, flag_inx}, result, v[i].x[34:32], v[i].x[31:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic held_v = 1'b0;
        logic [34:0] held = '0;
        logic [34:0] x;
        logic [47:0] m;
        logic [7:0] l;
        int e;
        logic s;
        exp_q.delete();
        gen_beat(m, l, e, s);
        while (got < 4 && cyc < 60) begin
            out_ready = (cyc >= 3);
            if (sent < 4) drive_beat(m, l, e, s);
            else set_idle();
            #1;
            if (cyc == 2) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    errors++;
                    $display("FAIL bp_in_ready: got in_ready=%b after %0d accepts, expected 0 after 2", in_ready, sent);
                end
            end
            if (held_v) begin
                checks++;
                if ({out_valid, flag_ovf, flag_unf, flag_inx, result} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL bp_stable: got valid=%b out=%h, expected 1 %h", out_valid,
                             {flag_ovf, flag_unf, flag_inx, result}, held);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(m, e, s));
                sent++;
                gen_beat(m, l, e, s);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got result=%h with nothing pending, expected no output", result);
                end else begin
                    x = exp_q.pop_front();
                    if ({flag_ovf, flag_unf, flag_inx, result} !== x) begin
                        errors++;
                        $display("FAIL bp_order: got %h, expected %h", {flag_ovf, flag_unf, flag_inx, result}, x);
                    end
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = {flag_ovf, flag_unf, flag_inx, result};
            @(negedge clk);
            cyc++;
        end
        set_idle();
        checks++;
        if (got != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d results with %0d pending, expected 4 and 0", got, exp_q.size());
        end
    endtask

    task automatic test_random(input int n);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic have = 1'b0;
        logic held_v = 1'b0;
        logic [34:0] held = '0;
        logic [34:0] x;
        logic [47:0] m;
        logic [7:0] l;
        int e;
        logic s;
        exp_q.delete();
        while (got < n && cyc < 5000) begin
            if (!have && sent < n && $urandom_range(0, 3) != 0) begin
                gen_beat(m, l, e, s);
                have = 1'b1;
            end
            if (have) drive_beat(m, l, e, s);
            else set_idle();
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held_v) begin
                checks++;
                if ({out_valid, flag_ovf, flag_unf, flag_inx, result} !== {1'b1, held}) begin
                    errors++;
                    $display("FAIL rnd_stable: got valid=%b out=%h, expected 1 %h", out_valid,
                             {flag_ovf, flag_unf, flag_inx, result}, held);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(m, e, s));
                sent++;
                have = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got result=%h with nothing pending, expected no output", result);
                end else begin
                    x = exp_q.pop_front();
                    if ({flag_ovf, flag_unf, flag_inx, result} !== x) begin
                        errors++;
                        $display("FAIL rnd_result: got %h, expected %h", {flag_ovf, flag_unf, flag_inx, result}, x);
                    end
                end
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = {flag_ovf, flag_unf, flag_inx, result};
            @(negedge clk);
            cyc++;
        end
        set_idle();
        out_ready = 1'b1;
        checks++;
        if (got != n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_count: got %0d results with %0d pending, expected %0d and 0", got, exp_q.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        logic [47:0] m;
        logic [7:0] l;
        int e;
        logic s;
        out_ready = 1'b0;
        repeat (2) begin
            gen_beat(m, l, e, s);
            if (m == 48'h0) m = 48'h1;
            l = 8'd0;
            for (int i = 0; i < 48; i++) if (m[i]) l = 8'(i);
            drive_beat(m, l, e, s);
            @(negedge clk);
        end
        set_idle();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight: got out_valid=%b before reset, expected 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, result, flag_ovf, flag_unf, flag_inx, in_ready} !== {1'b0, 32'h0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b result=%h flags=%b ready=%b, expected 0 00000000 000 1",
                     out_valid, result, {flag_ovf, flag_unf, flag_inx}, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_stale: got %0d stale outputs, in_ready=%b, expected 0 and 1", seen, in_ready);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random(300);
        test_reset_midflight();
        test_random(60);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
